// File: rtl/event_unit_pkg.sv
// Shared types and register map for the event-unit core sleep controller.
package event_unit_pkg;

    typedef enum logic [1:0] {
        SLP_RUN   = 2'd0,
        SLP_DRAIN = 2'd1,
        SLP_SLEEP = 2'd2,
        SLP_WAKE  = 2'd3
    } sleep_state_e;

    localparam logic [1:0] REG_SLP_CTRL = 2'd0;
    localparam logic [1:0] REG_SLP_MASK = 2'd1;
    localparam logic [1:0] REG_SLP_WDLY = 2'd2;
    localparam logic [1:0] REG_SLP_STAT = 2'd3;

    localparam int unsigned STAT_CNT_W     = 16;
    localparam int unsigned STAT_ABORT_BIT = 16;

endpackage

// File: rtl/core_sleep_ctrl.sv
// APB-controlled core sleep sequencer: drains the core, gates its clock and
// re-enables it on a masked wake source after a programmable settle delay.
module core_sleep_ctrl
    import event_unit_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned N_SRC          = 4,
    parameter int unsigned WAKE_DLY_W     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_SRC-1:0]          wake_src_i,
    input  logic                      core_busy_i,
    output logic                      clk_en_o,
    output logic                      fetch_en_o
);

    sleep_state_e              state_q, state_d;
    logic [N_SRC-1:0]          mask_q;
    logic [WAKE_DLY_W-1:0]     wdly_q;
    logic [WAKE_DLY_W-1:0]     dly_q, dly_d;
    logic [STAT_CNT_W-1:0]     cnt_q;
    logic                      abort_q;
    logic                      access, wr_en, ctrl_wr, stat_wr;
    logic                      wake, cnt_inc, abort_set;
    logic [1:0]                reg_idx;
    logic                      unused_ok;

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;

    assign reg_idx = PADDR[3:2];
    assign access  = PSEL & PENABLE;
    assign wr_en   = access & PWRITE;
    assign ctrl_wr = wr_en & (reg_idx == REG_SLP_CTRL) & PWDATA[0];
    assign stat_wr = wr_en & (reg_idx == REG_SLP_STAT);
    assign wake    = |(wake_src_i & mask_q);

    assign unused_ok = ^{PADDR[APB_ADDR_WIDTH-1:4], PADDR[1:0], PWDATA[31:WAKE_DLY_W]};

    // Configuration registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            mask_q <= '0;
            wdly_q <= '0;
        end else if (wr_en) begin
            if (reg_idx == REG_SLP_MASK) mask_q <= PWDATA[N_SRC-1:0];
            if (reg_idx == REG_SLP_WDLY) wdly_q <= PWDATA[WAKE_DLY_W-1:0];
        end
    end

    // Combinational read mux
    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            case (reg_idx)
                REG_SLP_CTRL: PRDATA = 32'(state_q);
                REG_SLP_MASK: PRDATA = 32'(mask_q);
                REG_SLP_WDLY: PRDATA = 32'(wdly_q);
                default:      PRDATA = {15'b0, abort_q, cnt_q};
            endcase
        end
    end

    // State, delay counter and registered outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= SLP_RUN;
            dly_q      <= '0;
            clk_en_o   <= 1'b1;
            fetch_en_o <= 1'b1;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            clk_en_o   <= (state_d != SLP_SLEEP);
            fetch_en_o <= (state_d == SLP_RUN);
        end
    end

    // Next-state logic; wake takes priority over drain completion
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_inc   = 1'b0;
        abort_set = 1'b0;
        case (state_q)
            SLP_RUN: begin
                if (ctrl_wr) begin
                    if (wake) abort_set = 1'b1;
                    else      state_d   = SLP_DRAIN;
                end
            end
            SLP_DRAIN: begin
                if (wake) begin
                    state_d   = SLP_RUN;
                    abort_set = 1'b1;
                end else if (!core_busy_i) begin
                    state_d = SLP_SLEEP;
                    cnt_inc = 1'b1;
                end
            end
            SLP_SLEEP: begin
                if (wake) begin
                    state_d = SLP_WAKE;
                    dly_d   = wdly_q;
                end
            end
            default: begin
                if (dly_q == '0) state_d = SLP_RUN;
                else             dly_d   = dly_q - WAKE_DLY_W'(1);
            end
        endcase
    end

    // Sleep-entry counter and sticky abort; a STAT write beats any update
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else if (stat_wr) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + STAT_CNT_W'(1);
            if (abort_set) abort_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_core_sleep_ctrl.sv
// Directed self-checking bench for core_sleep_ctrl.
module tb_core_sleep_ctrl;

    logic        HCLK;
    logic        HRESETn;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [3:0]  wake_src_i;
    logic        core_busy_i;
    logic        clk_en_o;
    logic        fetch_en_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    localparam logic [11:0] A_CTRL = 12'h000;
    localparam logic [11:0] A_MASK = 12'h004;
    localparam logic [11:0] A_WDLY = 12'h008;
    localparam logic [11:0] A_STAT = 12'h00C;

    core_sleep_ctrl dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .wake_src_i  (wake_src_i),
        .core_busy_i (core_busy_i),
        .clk_en_o    (clk_en_o),
        .fetch_en_o  (fetch_en_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
        @(negedge HCLK);
        PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    // Zero-cycle read: PRDATA is combinational from the registers
    task automatic check_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b1;
        #1 d = PRDATA;
        PSEL = 1'b0; PENABLE = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic check_outs(input string tag, input logic clk_exp, input logic fetch_exp);
        check({tag, "_clk_en"}, 32'(clk_en_o), 32'(clk_exp));
        check({tag, "_fetch_en"}, 32'(fetch_en_o), 32'(fetch_exp));
    endtask

    initial begin
        HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
        wake_src_i = '0; core_busy_i = 1'b0;
        #12;
        check_outs("reset", 1'b1, 1'b1);
        check_reg("reset_ctrl", A_CTRL, 32'd0);
        check_reg("reset_stat", A_STAT, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        check("pready", 32'(PREADY), 32'd1);
        check("pslverr", 32'(PSLVERR), 32'd0);

        // 1: sleep entry with idle core
        apb_write(A_MASK, 32'h1);
        apb_write(A_WDLY, 32'h3);
        check_reg("mask_rd", A_MASK, 32'h1);
        check_reg("wdly_rd", A_WDLY, 32'h3);
        apb_write(A_CTRL, 32'h1);
        check_reg("t1_drain", A_CTRL, 32'd1);
        check_outs("t1_drain", 1'b1, 1'b0);
        @(negedge HCLK);
        check_reg("t1_sleep", A_CTRL, 32'd2);
        check_outs("t1_sleep", 1'b0, 1'b0);
        check_reg("t1_stat", A_STAT, 32'd1);

        // 2: wake with WDLY=3 gives four WAKE cycles
        wake_src_i = 4'b0001;
        @(negedge HCLK);
        wake_src_i = 4'b0000;
        check_reg("t2_wake", A_CTRL, 32'd3);
        check_outs("t2_wake0", 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge HCLK);
            check_outs($sformatf("t2_wake%0d", i), 1'b1, 1'b0);
        end
        @(negedge HCLK);
        check_outs("t2_run", 1'b1, 1'b1);
        check_reg("t2_run", A_CTRL, 32'd0);

        // 3: busy core holds DRAIN for ten cycles
        core_busy_i = 1'b1;
        apb_write(A_CTRL, 32'h1);
        for (int i = 1; i <= 9; i++) begin
            @(negedge HCLK);
            check_reg($sformatf("t3_drain%0d", i), A_CTRL, 32'd1);
        end
        core_busy_i = 1'b0;
        @(negedge HCLK);
        check_reg("t3_sleep", A_CTRL, 32'd2);
        check_reg("t3_stat", A_STAT, 32'd2);
        wake_src_i = 4'b0001;
        repeat (5) @(negedge HCLK);
        wake_src_i = 4'b0000;
        check_reg("t3_run", A_CTRL, 32'd0);

        // 4: request with wake already high is dropped and aborts
        apb_write(A_MASK, 32'h2);
        wake_src_i = 4'b0010;
        apb_write(A_CTRL, 32'h1);
        check_reg("t4_state", A_CTRL, 32'd0);
        check_outs("t4", 1'b1, 1'b1);
        check_reg("t4_stat", A_STAT, 32'h0001_0002);
        wake_src_i = 4'b0000;
        apb_write(A_STAT, 32'h0);
        check_reg("t4_clr", A_STAT, 32'd0);

        // 5: wake and busy-drop in the same DRAIN cycle -> wake wins
        core_busy_i = 1'b1;
        apb_write(A_CTRL, 32'h1);
        check_reg("t5_drain", A_CTRL, 32'd1);
        core_busy_i = 1'b0;
        wake_src_i = 4'b0010;
        @(negedge HCLK);
        wake_src_i = 4'b0000;
        check_reg("t5_state", A_CTRL, 32'd0);
        check_reg("t5_stat", A_STAT, 32'h0001_0000);
        apb_write(A_STAT, 32'h0);
        check_reg("t5_clr", A_STAT, 32'd0);

        // STAT clear coincident with sleep-entry increment: clear wins
        core_busy_i = 1'b1;
        apb_write(A_CTRL, 32'h1);
        @(negedge HCLK);
        PADDR = A_STAT; PWDATA = '0; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        core_busy_i = 1'b0;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        check_reg("clr_win_state", A_CTRL, 32'd2);
        check_reg("clr_win_stat", A_STAT, 32'd0);
        wake_src_i = 4'b0010;
        repeat (5) @(negedge HCLK);
        wake_src_i = 4'b0000;
        check_reg("clr_win_run", A_CTRL, 32'd0);

        // 6: unmasked wake is ignored; reset mid-sleep recovers
        apb_write(A_MASK, 32'h0);
        apb_write(A_CTRL, 32'h1);
        @(negedge HCLK);
        wake_src_i = 4'hF;
        repeat (5) @(negedge HCLK);
        check_reg("t6_sleep", A_CTRL, 32'd2);
        check_outs("t6_sleep", 1'b0, 1'b0);
        check_reg("t6_stat", A_STAT, 32'd1);
        #1 HRESETn = 1'b0;
        #1;
        check_outs("t6_rst", 1'b1, 1'b1);
        check_reg("t6_rst_ctrl", A_CTRL, 32'd0);
        check_reg("t6_rst_wdly", A_WDLY, 32'd0);
        check_reg("t6_rst_stat", A_STAT, 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        wake_src_i = 4'h0;
        @(negedge HCLK);
        check_outs("t6_post", 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
